iic_target_mem: RTL and testbench

- I2C target (responder) for the `iic_top` controller: an addressable byte register file with an auto-incrementing pointer, standard 7-bit addressing, open-drain SDA.
- Sits on the bus opposite `iic_top`.
- The local side exposes a simple register port so SoC logic can preload or inspect bytes.
- SCL/SDA are oversampled on clk; no clock stretching.

---
 rtl/iic_target_mem_if.sv | 25 ++
 rtl/iic_target_mem.sv | 219 +++++++++++++++++++++
 tb/tb_iic_target_mem.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iic_target_mem_if.sv
// Bus pins (SCL/SDA) and local register-port signals of the I2C target memory.
interface iic_target_mem_if #(
    parameter int unsigned AW = 4
);
    logic          scl_i;
    logic          sda_i;
    logic          sda_oe;
    logic          loc_wr_en;
    logic [AW-1:0] loc_addr;
    logic [7:0]    loc_wdata;
    logic [7:0]    loc_rdata;
    logic          busy;
    logic          wr_done;
    logic          rd_done;

    modport slave (
        input  scl_i, sda_i, loc_wr_en, loc_addr, loc_wdata,
        output sda_oe, loc_rdata, busy, wr_done, rd_done
    );

    modport master (
        output scl_i, sda_i, loc_wr_en, loc_addr, loc_wdata,
        input  sda_oe, loc_rdata, busy, wr_done, rd_done
    );
endinterface

// File: rtl/iic_target_mem.sv
// I2C target exposing a byte register file with an auto-incrementing pointer;
// SCL/SDA are oversampled on clk, SDA is driven open-drain through sda_oe.
module iic_target_mem #(
    parameter logic [6:0]  DEV_ADDR = 7'h03,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AW       = 4
) (
    input logic             clk,
    input logic             rst_n,
    iic_target_mem_if.slave bus
);
    localparam int unsigned CNT_W = 3;

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] ADDR      = 4'd1;
    localparam logic [3:0] ADDR_ACK  = 4'd2;
    localparam logic [3:0] PTR       = 4'd3;
    localparam logic [3:0] PTR_ACK   = 4'd4;
    localparam logic [3:0] WDATA     = 4'd5;
    localparam logic [3:0] WDATA_ACK = 4'd6;
    localparam logic [3:0] RDATA     = 4'd7;
    localparam logic [3:0] RACK      = 4'd8;
    localparam logic [3:0] IGNORE    = 4'd9;

    logic scl_s1, scl_s2, scl_h;
    logic sda_s1, sda_s2, sda_h;

    logic [3:0]       state, state_n;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [7:0]       shreg, shreg_n;
    logic [AW-1:0]    ptr, ptr_n;
    logic             rw, rw_n;
    logic             wr_seen, wr_seen_n;
    logic             sda_oe_q, sda_oe_n;
    logic             busy_q, busy_n;
    logic             wr_done_q, wr_done_n;
    logic             rd_done_q, rd_done_n;
    logic [7:0]       loc_rdata_q;
    logic             mem_we;
    logic [7:0]       mem [DEPTH];

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte, rd_byte;

    // Synchronisers idle high so leaving reset on a quiet bus produces no edges
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_h <= 1'b1;
            sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_h <= 1'b1;
        end else begin
            scl_s1 <= bus.scl_i; scl_s2 <= scl_s1; scl_h <= scl_s2;
            sda_s1 <= bus.sda_i; sda_s2 <= sda_s1; sda_h <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_h;
    assign scl_fall  = ~scl_s2 & scl_h;
    assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
    assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;
    assign rx_byte   = {shreg[6:0], sda_s2};
    assign rd_byte   = mem[ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            ptr       <= '0;
            rw        <= 1'b0;
            wr_seen   <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            ptr       <= ptr_n;
            rw        <= rw_n;
            wr_seen   <= wr_seen_n;
            sda_oe_q  <= sda_oe_n;
            busy_q    <= busy_n;
            wr_done_q <= wr_done_n;
            rd_done_q <= rd_done_n;
        end
    end

    // Bus conditions first; byte handling only when no START/STOP this cycle
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        ptr_n     = ptr;
        rw_n      = rw;
        wr_seen_n = wr_seen;
        sda_oe_n  = sda_oe_q;
        busy_n    = busy_q;
        wr_done_n = 1'b0;
        rd_done_n = 1'b0;
        mem_we    = 1'b0;

        if (stop_det) begin
            state_n   = IDLE;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
            wr_done_n = wr_seen;
            wr_seen_n = 1'b0;
        end else if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shreg_n   = rx_byte;
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(7)) begin
                            bit_cnt_n = '0;
                            if (state == ADDR) begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    state_n = ADDR_ACK;
                                    rw_n    = rx_byte[0];
                                end else begin
                                    state_n = IGNORE;
                                end
                            end else if (state == PTR) begin
                                ptr_n   = rx_byte[AW-1:0];
                                state_n = PTR_ACK;
                            end else begin
                                mem_we    = 1'b1;
                                ptr_n     = ptr + AW'(1);
                                wr_seen_n = 1'b1;
                                state_n   = WDATA_ACK;
                            end
                        end
                    end
                end
                // First fall pulls SDA for the ACK slot, second fall ends it
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt == '0) begin
                            sda_oe_n  = 1'b1;
                            bit_cnt_n = CNT_W'(1);
                            if (state == ADDR_ACK) busy_n = 1'b1;
                        end else begin
                            bit_cnt_n = '0;
                            sda_oe_n  = 1'b0;
                            if (state == ADDR_ACK && rw) begin
                                shreg_n  = rd_byte;
                                sda_oe_n = ~rd_byte[7];
                                state_n  = RDATA;
                            end else if (state == ADDR_ACK) begin
                                state_n = PTR;
                            end else begin
                                state_n = WDATA;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == CNT_W'(7)) begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = '0;
                            state_n   = RACK;
                        end else begin
                            sda_oe_n  = ~shreg[6];
                            shreg_n   = {shreg[6:0], 1'b0};
                            bit_cnt_n = bit_cnt + CNT_W'(1);
                        end
                    end
                end
                RACK: begin
                    if (bit_cnt == '0 && scl_rise) begin
                        ptr_n = ptr + AW'(1);
                        if (sda_s2) begin
                            rd_done_n = 1'b1;
                            state_n   = IGNORE;
                        end else begin
                            bit_cnt_n = CNT_W'(1);
                        end
                    end else if (bit_cnt != '0 && scl_fall) begin
                        bit_cnt_n = '0;
                        shreg_n   = rd_byte;
                        sda_oe_n  = ~rd_byte[7];
                        state_n   = RDATA;
                    end
                end
                IGNORE: sda_oe_n = 1'b0;
                default: begin
                    state_n  = IDLE;
                    sda_oe_n = 1'b0;
                end
            endcase
        end
    end

    // Local write first so a same-cycle I2C write to the same index wins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            loc_rdata_q <= '0;
        end else begin
            if (bus.loc_wr_en) mem[bus.loc_addr] <= bus.loc_wdata;
            if (mem_we) mem[ptr] <= rx_byte;
            loc_rdata_q <= mem[bus.loc_addr];
        end
    end

    assign bus.sda_oe    = sda_oe_q;
    assign bus.busy      = busy_q;
    assign bus.wr_done   = wr_done_q;
    assign bus.rd_done   = rd_done_q;
    assign bus.loc_rdata = loc_rdata_q;
endmodule

// File: tb/tb_iic_target_mem.sv
// Bench for iic_target_mem: bit-banged I2C controller, byte-level model and
// an expected-value queue for read-back data.
module tb_iic_target_mem;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    always #5 clk = ~clk;

    iic_target_mem_if #(.AW(AW)) bus ();
    assign bus.scl_i = scl_m;
    assign bus.sda_i = sda_m & ~bus.sda_oe;

    iic_target_mem #(.DEV_ADDR(7'h03), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int oe_cnt = 0, busy_cnt = 0, wr_cnt = 0, rd_cnt = 0;

    logic [7:0]    model_mem [DEPTH];
    logic [AW-1:0] model_ptr;
    logic [7:0]    exp_q [$];

    always @(posedge clk) begin
        if (bus.sda_oe)  oe_cnt   <= oe_cnt + 1;
        if (bus.busy)    busy_cnt <= busy_cnt + 1;
        if (bus.wr_done) wr_cnt   <= wr_cnt + 1;
        if (bus.rd_done) rd_cnt   <= rd_cnt + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        wait_clk(4); sda_m = 1'b1;
        wait_clk(4); scl_m = 1'b1;
        wait_clk(4); sda_m = 1'b0;
        wait_clk(4); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(4); sda_m = 1'b0;
        wait_clk(4); scl_m = 1'b1;
        wait_clk(4); sda_m = 1'b1;
        wait_clk(4);
    endtask

    // One SCL period; optionally holds loc_wr_en over the edge that samples this bit
    task automatic put_bit(input logic b, input bit collide, output logic seen);
        wait_clk(4); sda_m = b;
        wait_clk(4); scl_m = 1'b1;
        if (collide) begin
            bus.loc_wr_en = 1'b1;
            wait_clk(3);
            bus.loc_wr_en = 1'b0;
            wait_clk(1);
        end else begin
            wait_clk(4);
        end
        seen = bus.sda_i;
        wait_clk(4); scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit collide_last, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) put_bit(b[i], collide_last && (i == 0), s);
        put_bit(1'b1, 1'b0, ack);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            put_bit(1'b1, 1'b0, s);
            b[i] = s;
        end
        put_bit(mack, 1'b0, s);
    endtask

    task automatic loc_write(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.loc_addr = a; bus.loc_wdata = d; bus.loc_wr_en = 1'b1;
        @(negedge clk);
        bus.loc_wr_en = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic loc_read(input logic [AW-1:0] a);
        logic [7:0] e;
        exp_q.push_back(model_mem[a]);
        @(negedge clk) bus.loc_addr = a;
        wait_clk(2);
        e = exp_q.pop_front();
        n_total++;
        if (bus.loc_rdata !== e) $display("FAIL loc_rdata[%0d]: got %h want %h", a, bus.loc_rdata, e);
        else n_pass++;
    endtask

    task automatic i2c_read_check(input logic mack, input string nm);
        logic [7:0] got, e;
        recv_byte(mack, got);
        n_total++;
        if (exp_q.size() == 0) $display("FAIL %s: got %h want <empty queue>", nm, got);
        else begin
            e = exp_q.pop_front();
            if (got !== e) $display("FAIL %s: got %h want %h", nm, got, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        wait_clk(2);
        n_total++; if (bus.sda_oe !== 1'b0)    $display("FAIL rst_sda_oe: got %b want 0", bus.sda_oe);    else n_pass++;
        n_total++; if (bus.busy !== 1'b0)      $display("FAIL rst_busy: got %b want 0", bus.busy);        else n_pass++;
        n_total++; if (bus.wr_done !== 1'b0)   $display("FAIL rst_wr_done: got %b want 0", bus.wr_done);  else n_pass++;
        n_total++; if (bus.rd_done !== 1'b0)   $display("FAIL rst_rd_done: got %b want 0", bus.rd_done);  else n_pass++;
        n_total++; if (bus.loc_rdata !== 8'h0) $display("FAIL rst_loc_rdata: got %h want 00", bus.loc_rdata); else n_pass++;
    endtask

    task automatic test_write_local();
        logic [7:0] seq [4];
        logic ack;
        int   wr0;
        seq = '{8'h06, 8'h02, 8'hA5, 8'h5A};
        wr0 = wr_cnt;
        i2c_start();
        for (int i = 0; i < 4; i++) begin
            send_byte(seq[i], 1'b0, ack);
            n_total++; if (ack !== 1'b0) $display("FAIL wr_ack[%0d]: got %b want 0", i, ack); else n_pass++;
            if (i == 0) begin
                n_total++; if (bus.busy !== 1'b1) $display("FAIL wr_busy: got %b want 1", bus.busy); else n_pass++;
            end
        end
        i2c_stop();
        model_mem[2] = 8'hA5; model_mem[3] = 8'h5A; model_ptr = 4'd4;
        n_total++; if (wr_cnt - wr0 !== 1) $display("FAIL wr_done_pulses: got %0d want 1", wr_cnt - wr0); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL wr_busy_after_stop: got %b want 0", bus.busy); else n_pass++;
        loc_read(4'd3);
        loc_read(4'd2);
    endtask

    task automatic test_read_wrap();
        logic ack;
        int   rd0;
        loc_write(4'd15, 8'h11);
        loc_write(4'd0, 8'h22);
        loc_write(4'd1, 8'h77);
        rd0 = rd_cnt;
        i2c_start();
        send_byte(8'h06, 1'b0, ack);
        send_byte(8'h0F, 1'b0, ack);
        n_total++; if (ack !== 1'b0) $display("FAIL rd_ptr_ack: got %b want 0", ack); else n_pass++;
        model_ptr = 4'hF;
        i2c_start();
        n_total++; if (bus.busy !== 1'b0) $display("FAIL rs_busy: got %b want 0", bus.busy); else n_pass++;
        send_byte(8'h07, 1'b0, ack);
        n_total++; if (ack !== 1'b0) $display("FAIL rd_addr_ack: got %b want 0", ack); else n_pass++;
        exp_q.push_back(model_mem[model_ptr]); model_ptr = model_ptr + 4'd1;
        exp_q.push_back(model_mem[model_ptr]); model_ptr = model_ptr + 4'd1;
        i2c_read_check(1'b0, "rd_byte0");
        i2c_read_check(1'b1, "rd_byte1_wrap");
        i2c_stop();
        n_total++; if (rd_cnt - rd0 !== 1) $display("FAIL rd_done_pulses: got %0d want 1", rd_cnt - rd0); else n_pass++;
        // Pointer persisted at 1: a fresh read returns mem[1]
        i2c_start();
        send_byte(8'h07, 1'b0, ack);
        exp_q.push_back(model_mem[model_ptr]); model_ptr = model_ptr + 4'd1;
        i2c_read_check(1'b1, "rd_ptr_persist");
        i2c_stop();
    endtask

    task automatic test_mismatch();
        logic ack;
        int   oe0, busy0, wr0;
        oe0 = oe_cnt; busy0 = busy_cnt; wr0 = wr_cnt;
        i2c_start();
        send_byte(8'h0A, 1'b0, ack);
        n_total++; if (ack !== 1'b1) $display("FAIL mm_addr_ack: got %b want 1", ack); else n_pass++;
        send_byte(8'hFF, 1'b0, ack);
        n_total++; if (ack !== 1'b1) $display("FAIL mm_data_ack: got %b want 1", ack); else n_pass++;
        i2c_stop();
        n_total++; if (oe_cnt - oe0 !== 0)     $display("FAIL mm_sda_oe_cycles: got %0d want 0", oe_cnt - oe0);   else n_pass++;
        n_total++; if (busy_cnt - busy0 !== 0) $display("FAIL mm_busy_cycles: got %0d want 0", busy_cnt - busy0); else n_pass++;
        n_total++; if (wr_cnt - wr0 !== 0)     $display("FAIL mm_wr_done: got %0d want 0", wr_cnt - wr0);         else n_pass++;
        loc_read(model_ptr);
        loc_read(4'd5);
    endtask

    task automatic test_stop_midbyte();
        logic [7:0] seq [3];
        logic ack, s;
        int   wr0;
        wr0 = wr_cnt;
        i2c_start();
        send_byte(8'h06, 1'b0, ack);
        send_byte(8'h04, 1'b0, ack);
        put_bit(1'b1, 1'b0, s); put_bit(1'b1, 1'b0, s); put_bit(1'b0, 1'b0, s);
        i2c_stop();
        n_total++; if (bus.sda_oe !== 1'b0) $display("FAIL sm_sda_oe: got %b want 0", bus.sda_oe); else n_pass++;
        n_total++; if (bus.busy !== 1'b0)   $display("FAIL sm_busy: got %b want 0", bus.busy);     else n_pass++;
        n_total++; if (wr_cnt - wr0 !== 0)  $display("FAIL sm_wr_done: got %0d want 0", wr_cnt - wr0); else n_pass++;
        loc_read(4'd4);
        seq = '{8'h06, 8'h04, 8'hC3};
        wr0 = wr_cnt;
        i2c_start();
        for (int i = 0; i < 3; i++) begin
            send_byte(seq[i], 1'b0, ack);
            n_total++; if (ack !== 1'b0) $display("FAIL sm_retry_ack[%0d]: got %b want 0", i, ack); else n_pass++;
        end
        i2c_stop();
        model_mem[4] = 8'hC3; model_ptr = 4'd5;
        n_total++; if (wr_cnt - wr0 !== 1) $display("FAIL sm_retry_wr_done: got %0d want 1", wr_cnt - wr0); else n_pass++;
        loc_read(4'd4);
    endtask

    task automatic test_collision();
        logic ack;
        i2c_start();
        send_byte(8'h06, 1'b0, ack);
        send_byte(8'h05, 1'b0, ack);
        @(negedge clk);
        bus.loc_addr = 4'd5; bus.loc_wdata = 8'h99;
        send_byte(8'h3C, 1'b1, ack);
        n_total++; if (ack !== 1'b0) $display("FAIL col_ack: got %b want 0", ack); else n_pass++;
        i2c_stop();
        model_mem[5] = 8'h3C; model_ptr = 4'd6;
        loc_read(4'd5);
    endtask

    task automatic test_write_wrap();
        logic [7:0] seq [4];
        logic ack;
        seq = '{8'h06, 8'h0F, 8'hAB, 8'hCD};
        i2c_start();
        for (int i = 0; i < 4; i++) begin
            send_byte(seq[i], 1'b0, ack);
            n_total++; if (ack !== 1'b0) $display("FAIL ww_ack[%0d]: got %b want 0", i, ack); else n_pass++;
        end
        i2c_stop();
        model_mem[15] = 8'hAB; model_mem[0] = 8'hCD; model_ptr = 4'd1;
        loc_read(4'd15);
        loc_read(4'd0);
        loc_read(4'd1);
    endtask

    task automatic test_reset_midread();
        logic ack, s;
        logic exp_oe;
        i2c_start();
        send_byte(8'h06, 1'b0, ack);
        send_byte(8'h02, 1'b0, ack);
        i2c_start();
        send_byte(8'h07, 1'b0, ack);
        put_bit(1'b1, 1'b0, s);
        wait_clk(5);
        exp_oe = ~model_mem[2][6];
        n_total++; if (bus.sda_oe !== exp_oe) $display("FAIL rr_driving: got %b want %b", bus.sda_oe, exp_oe); else n_pass++;
        rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
        @(posedge clk); #1;
        n_total++; if (bus.sda_oe !== 1'b0) $display("FAIL rr_sda_oe: got %b want 0", bus.sda_oe); else n_pass++;
        wait_clk(3);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        model_ptr = '0;
        for (int i = 0; i < DEPTH; i++) loc_read(AW'(i));
        i2c_start();
        send_byte(8'h07, 1'b0, ack);
        n_total++; if (ack !== 1'b0) $display("FAIL rr_addr_ack: got %b want 0", ack); else n_pass++;
        exp_q.push_back(model_mem[model_ptr]);
        i2c_read_check(1'b1, "rr_read_ptr0");
        i2c_stop();
    endtask

    initial begin
        bus.loc_wr_en = 1'b0;
        bus.loc_addr  = '0;
        bus.loc_wdata = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        model_ptr = '0;
        wait_clk(4);
        rst_n = 1'b1;
        test_reset();
        test_write_local();
        test_read_wrap();
        test_mismatch();
        test_stop_midbyte();
        test_collision();
        test_write_wrap();
        test_reset_midread();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
